uart_fifo_periph: RTL and testbench
===================================

# uart_fifo_periph

- Memory-mapped UART peripheral with 8-bit RX and TX FIFOs.
- Sits on the pipeline data-memory port, downstream of the core's address decode, in the `7000'0000h` region.
- Replaces the single-character inline UART logic of the top level.
- Registered read data arrives one cycle after the request, the same timing as block RAM, so the existing `mem_rdata` mux can consume it directly.

## Interface
Parameters:
- CLOCK_DIV, 104, clk cycles per UART bit (12 MHz / 115200); legal range 4..65535.
- FIFO_AW, 3, log2 FIFO depth; each FIFO holds 2^FIFO_AW bytes.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- sel  in  1  request targets this block (`mem_valid` & region decode, done outside).
- write  in  1  1 = store, 0 = load.
- wmask  in  4  byte enables of store.
- wdata  in  32  store data.
- addr  in  2  word offset (`mem_addr[3:2]`).
- rdata  out  32  load data, valid the cycle after the request; reset 0.
- uart_rx  in  1  serial input, asynchronous.
- uart_tx  out  1  serial output; reset 1.
- irq_rx  out  1  RX FIFO non-empty, registered; reset 0.

## Operation
Register map (word offsets):
- 0 STATUS/TXDATA.
  - Read: bit0 TX not full, bit1 RX not empty, bit2 RX overrun (sticky), bit3 framing error (sticky), bit4 TX idle (FIFO empty and shifter idle); other bits 0.
  - Write with `wmask[0]`: push `wdata[7:0]` into the TX FIFO. The push is dropped silently when the FIFO is full.
- 1 RXDATA.
  - Read: returns `{24'b0, head}` and pops the FIFO in the request cycle.
  - If the FIFO is empty: returns 0 and does not pop.
  - Writes are ignored.
- 2 LEVEL, read-only: [7:0] TX count, [15:8] RX count.
- 3 CTRL.
  - Write: bit2 = 1 clears overrun; bit3 = 1 clears framing error.
  - Bit0 loopback: see Configuration.
  - Read returns bit0; all other bits read 0.

TX engine:
- States: IDLE, START, DATA, STOP.
- IDLE with FIFO non-empty: pop one byte into the shifter and go to START.
- Bit order: start (0), 8 data bits LSB first, stop (1).
- Each bit lasts exactly CLOCK_DIV cycles.
- STOP goes back to IDLE, or straight to START if the FIFO is non-empty. There is no idle gap between frames.

RX engine:
- Input path: 2-flop synchronizer.
- States: IDLE, START, DATA, STOP.
- IDLE: synchronized low → START, sampling at CLOCK_DIV/2 (integer division).
- START: a high sample aborts back to IDLE (glitch reject).
- DATA: 8 samples spaced CLOCK_DIV apart.
- STOP sample:
  - High: push the byte. If the FIFO is full, drop the byte and set overrun.
  - Low: set framing error and discard the byte.
- After STOP, return to IDLE.

Boundary rules:
- RX push and pop in the same cycle on a full FIFO: both happen, no overrun.
- TX push and engine pop in the same cycle: both happen.
- Pointers wrap modulo depth. Count width is FIFO_AW+1.
- Reset mid-frame: `uart_tx` = 1 next cycle, both FIFOs empty, sticky flags cleared, both engines IDLE.

## Timing
- Read data is latched into `rdata` at the edge that ends the request cycle. Loads to other offsets update `rdata` the same way.
- TX store at cycle N:
  - The FIFO count increments at N+1.
  - The shifter loads at N+1.
  - The start bit appears on `uart_tx` at N+2.
- RX byte visibility: the STOP sample occurs 9.5·CLOCK_DIV cycles after the falling edge reaches the synchronizer output. STATUS bit1, `irq_rx` and LEVEL reflect the byte one cycle after that sample.
- Sticky flag set and clear in the same cycle: set wins.

## Configuration
- UART_LOOPBACK_EN defined:
  - CTRL bit0 is a writable register, reset 0.
  - When bit0 = 1, the RX synchronizer input is internal TX, and `uart_tx` is held at 1.
- UART_LOOPBACK_EN undefined:
  - CTRL bit0 reads 0 and writes are ignored.
  - No mux exists on the RX path.

## Structure
- Package `uart_pkg`:
  - Register offset constants.
  - STATUS bit indices.
  - CTRL bit indices.
  - Engine state enum (shared by TX and RX).
- Sub-module `sync_fifo`:
  - Parameterised by width and FIFO_AW.
  - Ports: push, pop, din, dout (head, combinational), full, empty, count.
  - Instantiated twice, for TX and RX.

## Test plan
All scenarios use CLOCK_DIV=8 and FIFO_AW=3.
- Reset → `uart_tx`=1, `irq_rx`=0; STATUS read returns 0x11; LEVEL returns 0.
- Store 0x55 to offset 0 at cycle N → `uart_tx` low from N+2 for 8 cycles, then 1,0,1,0,1,0,1,0,1 each 8 cycles; STATUS bit4=1 after the stop bit.
- 10 back-to-back stores 0x00..0x09 → 9 frames 0x00..0x08; 0x09 dropped; LEVEL[7:0] peaks at 8.
- Drive frame 0xA3 on `uart_rx` → `irq_rx`=1; read offset 1 returns 0xA3 next cycle; then STATUS bit1=0 and `irq_rx`=0.
- 9 RX frames 0x10..0x18 with no reads → STATUS bit2=1; 8 reads return 0x10..0x17; write 0x4 to offset 3 clears bit2.
- RX frame with stop bit low → bit3=1, RX count unchanged. A 3-cycle low pulse → no frame, no flag.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the memory-mapped UART peripheral: register word
// offsets, STATUS and CTRL bit positions, and the engine state type used by
// both the TX and RX serial engines.
// -----------------------------------------------------------------------------
package uart_pkg;

   // Register word offsets (mem_addr[3:2])
   localparam logic [1:0] REG_STATUS = 2'd0;   // read STATUS, write TXDATA
   localparam logic [1:0] REG_RXDATA = 2'd1;
   localparam logic [1:0] REG_LEVEL  = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   // STATUS bit indices
   localparam int ST_TX_NFULL  = 0;
   localparam int ST_RX_NEMPTY = 1;
   localparam int ST_OVERRUN   = 2;
   localparam int ST_FRAMING   = 3;
   localparam int ST_TX_IDLE   = 4;

   // CTRL bit indices
   localparam int CTRL_LOOPBACK = 0;
   localparam int CTRL_CLR_OVR  = 2;
   localparam int CTRL_CLR_FRM  = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head (dout) and an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is dropped.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   push, pop   write / read strobes (pop on empty is ignored)
//   din, dout   write data / current head
//   full, empty occupancy flags
//   count       number of stored entries (FIFO_AW+1 bits)
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH   = 8,
   parameter int FIFO_AW = 3
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               push,
   input  logic               pop,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   dout,
   output logic               full,
   output logic               empty,
   output logic [FIFO_AW:0]   count
);

   localparam int              DEPTH   = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);

   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q;
   logic               wr_en, rd_en;

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_C);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Pointers are FIFO_AW bits wide, so they wrap modulo depth.
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage has no reset; the count and pointers alone define which
   // entries are valid, and leaving the array unreset lets it map to RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_fifo_periph.sv
// -----------------------------------------------------------------------------
// uart_fifo_periph
// Memory-mapped 8N1 UART with TX and RX FIFOs on the data-memory port.
// Load data is registered and valid the cycle after the request.
// Optional feature macro: UART_LOOPBACK_EN (CTRL bit0 routes TX into RX).
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   sel, write       request strobe, 1 = store / 0 = load
//   wmask, wdata     store byte enables and data
//   addr             word offset
//   rdata            registered load data
//   uart_rx, uart_tx serial input (asynchronous) / serial output
//   irq_rx           RX FIFO non-empty
// -----------------------------------------------------------------------------
module uart_fifo_periph
   import uart_pkg::*;
#(
   parameter int CLOCK_DIV = 104,
   parameter int FIFO_AW   = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        sel,
   input  logic        write,
   input  logic [3:0]  wmask,
   input  logic [31:0] wdata,
   input  logic [1:0]  addr,
   output logic [31:0] rdata,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq_rx
);

   localparam logic [15:0] DIV_C  = 16'(CLOCK_DIV);
   localparam logic [15:0] DIV_M1 = 16'(CLOCK_DIV - 1);
   localparam logic [15:0] HALF_C = 16'(CLOCK_DIV / 2);

   // Bus decode
   logic rd_req, wr_req, tx_push, ctrl_wr, rx_pop;
   assign rd_req  = sel && !write;
   assign wr_req  = sel && write && wmask[0];
   assign tx_push = wr_req && (addr == REG_STATUS);
   assign ctrl_wr = wr_req && (addr == REG_CTRL);

   // FIFOs
   logic [7:0]       tx_head, rx_head;
   logic             tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;
   logic [FIFO_AW:0] tx_count, rx_count;
   logic [7:0]       rx_shift_q;

   assign rx_pop = rd_req && (addr == REG_RXDATA) && !rx_empty;

   sync_fifo #(.WIDTH(8), .FIFO_AW(FIFO_AW)) u_tx_fifo (
      .clk(clk), .rstn(rstn), .push(tx_push), .pop(tx_pop), .din(wdata[7:0]),
      .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count));

   sync_fifo #(.WIDTH(8), .FIFO_AW(FIFO_AW)) u_rx_fifo (
      .clk(clk), .rstn(rstn), .push(rx_push), .pop(rx_pop), .din(rx_shift_q),
      .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count));

   // ---------------- TX engine ----------------
   uart_state_e tx_state_q;
   logic [15:0] tx_cnt_q;
   logic [2:0]  tx_bits_q;
   logic [7:0]  tx_shift_q;
   logic        tx_q, tx_bit_end;

   assign tx_bit_end = (tx_cnt_q == DIV_M1);
   // Pop when idle, or at the end of a stop bit to chain frames with no gap.
   assign tx_pop = !tx_empty && ((tx_state_q == S_IDLE) ||
                                 (tx_state_q == S_STOP && tx_bit_end));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tx_state_q <= S_IDLE;
         tx_q       <= 1'b1;
         tx_cnt_q   <= '0;
         tx_bits_q  <= '0;
         tx_shift_q <= '0;
      end else begin
         case (tx_state_q)
            S_IDLE: if (tx_pop) begin
               tx_shift_q <= tx_head;
               tx_q       <= 1'b0;
               tx_cnt_q   <= '0;
               tx_state_q <= S_START;
            end
            S_START: if (tx_bit_end) begin
               tx_cnt_q   <= '0;
               tx_bits_q  <= '0;
               tx_q       <= tx_shift_q[0];
               tx_state_q <= S_DATA;
            end else tx_cnt_q <= tx_cnt_q + 1'b1;
            S_DATA: if (tx_bit_end) begin
               tx_cnt_q <= '0;
               if (tx_bits_q == 3'd7) begin
                  tx_q       <= 1'b1;
                  tx_state_q <= S_STOP;
               end else begin
                  tx_bits_q  <= tx_bits_q + 1'b1;
                  tx_shift_q <= tx_shift_q >> 1;
                  tx_q       <= tx_shift_q[1];
               end
            end else tx_cnt_q <= tx_cnt_q + 1'b1;
            default: if (tx_bit_end) begin
               tx_cnt_q <= '0;
               if (tx_pop) begin
                  tx_shift_q <= tx_head;
                  tx_q       <= 1'b0;
                  tx_state_q <= S_START;
               end else tx_state_q <= S_IDLE;
            end else tx_cnt_q <= tx_cnt_q + 1'b1;
         endcase
      end
   end

   // ---------------- Loopback option ----------------
   logic rx_in, ctrl_rd;
`ifdef UART_LOOPBACK_EN
   logic lb_q;
   always_ff @(posedge clk) begin
      if (!rstn)        lb_q <= 1'b0;
      else if (ctrl_wr) lb_q <= wdata[CTRL_LOOPBACK];
   end
   assign rx_in   = lb_q ? tx_q : uart_rx;
   assign uart_tx = lb_q ? 1'b1 : tx_q;
   assign ctrl_rd = lb_q;
`else
   assign rx_in   = uart_rx;
   assign uart_tx = tx_q;
   assign ctrl_rd = 1'b0;
`endif

   // ---------------- RX engine ----------------
   uart_state_e rx_state_q;
   logic [15:0] rx_cnt_q;
   logic [2:0]  rx_bits_q;
   logic        rx_s1_q, rx_s2_q, rx_stop_smp, frm_set, ovr_set;

   // Counter holds the cycle index since the falling edge was seen, so the
   // start sample lands at CLOCK_DIV/2 and each later sample CLOCK_DIV on.
   assign rx_stop_smp = (rx_state_q == S_STOP) && (rx_cnt_q == DIV_C);
   assign rx_push     = rx_stop_smp && rx_s2_q;
   assign frm_set     = rx_stop_smp && !rx_s2_q;
   assign ovr_set     = rx_push && rx_full && !rx_pop;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_bits_q  <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_s1_q <= rx_in;
         rx_s2_q <= rx_s1_q;
         case (rx_state_q)
            S_IDLE: if (!rx_s2_q) begin
               rx_cnt_q   <= 16'd1;
               rx_state_q <= S_START;
            end
            S_START: if (rx_cnt_q == HALF_C) begin
               rx_cnt_q   <= 16'd1;
               rx_bits_q  <= '0;
               rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;   // high = glitch
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            S_DATA: if (rx_cnt_q == DIV_C) begin
               rx_cnt_q   <= 16'd1;
               rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};  // LSB arrives first
               rx_bits_q  <= rx_bits_q + 1'b1;
               if (rx_bits_q == 3'd7) rx_state_q <= S_STOP;
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            default: if (rx_stop_smp) rx_state_q <= S_IDLE;
                     else rx_cnt_q <= rx_cnt_q + 1'b1;
         endcase
      end
   end

   // ---------------- Sticky flags and read data ----------------
   logic        ovr_q, ovr_d, frm_q, frm_d;
   logic [31:0] rdata_q, rdata_d;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      ovr_d   = ovr_q;
      frm_d   = frm_q;
      rdata_d = rdata_q;
      if (ctrl_wr && wdata[CTRL_CLR_OVR]) ovr_d = 1'b0;
      if (ctrl_wr && wdata[CTRL_CLR_FRM]) frm_d = 1'b0;
      if (ovr_set) ovr_d = 1'b1;   // set beats a same-cycle clear
      if (frm_set) frm_d = 1'b1;
      if (rd_req) begin
         rdata_d = '0;
         case (addr)
            REG_STATUS: begin
               rdata_d[ST_TX_NFULL]  = !tx_full;
               rdata_d[ST_RX_NEMPTY] = !rx_empty;
               rdata_d[ST_OVERRUN]   = ovr_q;
               rdata_d[ST_FRAMING]   = frm_q;
               rdata_d[ST_TX_IDLE]   = tx_empty && (tx_state_q == S_IDLE);
            end
            REG_RXDATA: if (!rx_empty) rdata_d[7:0] = rx_head;
            REG_LEVEL: begin
               rdata_d[FIFO_AW:0]     = tx_count;
               rdata_d[8+FIFO_AW:8]   = rx_count;
            end
            default: rdata_d[CTRL_LOOPBACK] = ctrl_rd;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ovr_q   <= 1'b0;
         frm_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ovr_q   <= ovr_d;
         frm_q   <= frm_d;
         rdata_q <= rdata_d;
      end
   end

   assign rdata  = rdata_q;
   // Driven straight from the RX count flops: no combinational input path.
   assign irq_rx = !rx_empty;

   logic unused_bits;
   assign unused_bits = ^{wdata[31:8], wmask[3:1]};

endmodule

// File: tb/tb_uart_fifo_periph.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo_periph
// Directed testbench for uart_fifo_periph with CLOCK_DIV=8, FIFO_AW=3.
// Inputs change on the falling clock edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_fifo_periph;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        sel = 1'b0;
   logic        write = 1'b0;
   logic [3:0]  wmask = 4'h0;
   logic [31:0] wdata = '0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] rdata;
   logic        uart_rx = 1'b1;
   logic        uart_tx;
   logic        irq_rx;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

`ifdef UART_LOOPBACK_EN
   localparam logic [31:0] CTRL_EXP = 32'h1;
`else
   localparam logic [31:0] CTRL_EXP = 32'h0;
`endif

   uart_fifo_periph #(.CLOCK_DIV(8), .FIFO_AW(3)) dut (
      .clk(clk), .rstn(rstn), .sel(sel), .write(write), .wmask(wmask),
      .wdata(wdata), .addr(addr), .rdata(rdata), .uart_rx(uart_rx),
      .uart_tx(uart_tx), .irq_rx(irq_rx));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; write = 1'b1; addr = a; wdata = d; wmask = 4'hF;
      @(negedge clk);
      sel = 1'b0; write = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; write = 1'b0; addr = a;
      @(negedge clk);
      sel = 1'b0;
      d = rdata;
   endtask

   // Drives one 80-cycle frame; optionally issues an RXDATA read in the
   // cycle of the stop sample (cycle 78 from the falling edge).
   task automatic send_rx(input logic [7:0] d, input logic stop, input logic pop_at_stop,
                          output logic irq78, output logic irq79, output logic [31:0] popped);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      popped = '0; irq78 = 1'b0; irq79 = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         uart_rx = fr[i/8];
         if (i == 78) begin
            irq78 = irq_rx;
            if (pop_at_stop) begin sel = 1'b1; write = 1'b0; addr = 2'd1; end
         end
         if (i == 79) begin
            irq79 = irq_rx;
            if (pop_at_stop) begin sel = 1'b0; popped = rdata; end
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
      total++; if (irq_rx !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq_rx); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      rstn = 1'b1;
      bus_read(2'd0, d);
      total++; if (d !== 32'h11) begin bad++; $display("FAIL reset_status: got %h want 11", d); end
      bus_read(2'd2, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_level: got %h want 0", d); end
      bus_read(2'd3, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", d); end
   endtask

   task automatic test_tx_single();
      logic [9:0]  fr;
      logic [31:0] d;
      fr = {1'b1, 8'h55, 1'b0};
      bus_write(2'd0, 32'h55);           // returns in cycle N+1
      total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL tx_latency: got %b want 1 at N+1", uart_tx); end
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         total++;
         if (uart_tx !== fr[i/8]) begin
            bad++; $display("FAIL tx_frame cycle %0d: got %b want %b", i, uart_tx, fr[i/8]);
         end
      end
      bus_read(2'd0, d);
      total++; if (d !== 32'h11) begin bad++; $display("FAIL tx_idle_status: got %h want 11", d); end
   endtask

   task automatic capture_tx_frames();
      int last_start;
      int t;
      logic [7:0] b;
      last_start = 0;
      for (int f = 0; f < 9; f++) begin
         t = 0;
         while (uart_tx !== 1'b0 && t < 400) begin @(negedge clk); t++; end
         total++;
         if (t >= 400) begin bad++; $display("FAIL b2b_start frame %0d: no start bit in 400 cycles", f); return; end
         if (f > 0) begin
            total++;
            if (cyc - last_start !== 80) begin
               bad++; $display("FAIL b2b_gap frame %0d: spacing %0d want 80", f, cyc - last_start);
            end
         end
         last_start = cyc;
         repeat (4) @(negedge clk);
         for (int k = 0; k < 8; k++) begin
            repeat (8) @(negedge clk);
            b[k] = uart_tx;
         end
         total++; if (b !== f[7:0]) begin bad++; $display("FAIL b2b_byte frame %0d: got %h want %h", f, b, f[7:0]); end
         repeat (8) @(negedge clk);
         total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL b2b_stop frame %0d: got %b want 1", f, uart_tx); end
      end
      t = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) t++;
      end
      total++; if (t != 0) begin bad++; $display("FAIL b2b_extra: line low %0d cycles want 0", t); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               sel = 1'b1; write = 1'b1; addr = 2'd0; wmask = 4'hF; wdata = 32'(i);
            end
            @(negedge clk);
            write = 1'b0; addr = 2'd2;
            @(negedge clk);
            sel = 1'b0;
            total++; if (rdata !== 32'h8) begin bad++; $display("FAIL b2b_level_peak: got %h want 8", rdata); end
         end
         capture_tx_frames();
      join
      bus_read(2'd0, d);
      total++; if (d !== 32'h11) begin bad++; $display("FAIL b2b_status_end: got %h want 11", d); end
   endtask

   task automatic test_rx_single();
      logic i78, i79;
      logic [31:0] p, d;
      send_rx(8'hA3, 1'b1, 1'b0, i78, i79, p);
      total++; if (i78 !== 1'b0) begin bad++; $display("FAIL rx_irq_early: got %b want 0", i78); end
      total++; if (i79 !== 1'b1) begin bad++; $display("FAIL rx_irq_on_time: got %b want 1", i79); end
      bus_read(2'd2, d);
      total++; if (d !== 32'h100) begin bad++; $display("FAIL rx_level: got %h want 100", d); end
      bus_read(2'd1, d);
      total++; if (d !== 32'hA3) begin bad++; $display("FAIL rx_data: got %h want a3", d); end
      total++; if (irq_rx !== 1'b0) begin bad++; $display("FAIL rx_irq_clear: got %b want 0", irq_rx); end
      bus_read(2'd0, d);
      total++; if (d !== 32'h11) begin bad++; $display("FAIL rx_status_empty: got %h want 11", d); end
      bus_read(2'd1, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rx_read_empty: got %h want 0", d); end
   endtask

   task automatic test_overrun();
      logic i78, i79;
      logic [31:0] p, d;
      for (int f = 0; f < 9; f++) send_rx(8'h10 + 8'(f), 1'b1, 1'b0, i78, i79, p);
      bus_read(2'd0, d);
      total++; if (d !== 32'h17) begin bad++; $display("FAIL ovr_status: got %h want 17", d); end
      bus_read(2'd2, d);
      total++; if (d !== 32'h800) begin bad++; $display("FAIL ovr_level: got %h want 800", d); end
      for (int k = 0; k < 8; k++) begin
         bus_read(2'd1, d);
         total++;
         if (d !== 32'h10 + 32'(k)) begin bad++; $display("FAIL ovr_read %0d: got %h want %h", k, d, 32'h10 + 32'(k)); end
      end
      bus_read(2'd0, d);
      total++; if (d !== 32'h15) begin bad++; $display("FAIL ovr_sticky: got %h want 15", d); end
      bus_write(2'd3, 32'h4);
      bus_read(2'd0, d);
      total++; if (d !== 32'h11) begin bad++; $display("FAIL ovr_clear: got %h want 11", d); end
      // Full FIFO with push and pop in the same cycle: no overrun.
      for (int f = 0; f < 8; f++) send_rx(8'h20 + 8'(f), 1'b1, 1'b0, i78, i79, p);
      send_rx(8'h28, 1'b1, 1'b1, i78, i79, p);
      total++; if (p !== 32'h20) begin bad++; $display("FAIL full_pop_data: got %h want 20", p); end
      bus_read(2'd0, d);
      total++; if (d !== 32'h13) begin bad++; $display("FAIL full_pushpop_status: got %h want 13", d); end
      bus_read(2'd2, d);
      total++; if (d !== 32'h800) begin bad++; $display("FAIL full_pushpop_level: got %h want 800", d); end
      for (int k = 0; k < 8; k++) begin
         bus_read(2'd1, d);
         total++;
         if (d !== 32'h21 + 32'(k)) begin bad++; $display("FAIL full_drain %0d: got %h want %h", k, d, 32'h21 + 32'(k)); end
      end
   endtask

   task automatic test_framing();
      logic i78, i79;
      logic [31:0] p, d;
      send_rx(8'h5A, 1'b0, 1'b0, i78, i79, p);
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      bus_read(2'd0, d);
      total++; if (d !== 32'h19) begin bad++; $display("FAIL frm_status: got %h want 19", d); end
      bus_read(2'd2, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL frm_level: got %h want 0", d); end
      bus_write(2'd3, 32'h8);
      bus_read(2'd0, d);
      total++; if (d !== 32'h11) begin bad++; $display("FAIL frm_clear: got %h want 11", d); end
      // 3-cycle glitch must be rejected.
      @(negedge clk); uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      repeat (120) @(negedge clk);
      total++; if (irq_rx !== 1'b0) begin bad++; $display("FAIL glitch_irq: got %b want 0", irq_rx); end
      bus_read(2'd0, d);
      total++; if (d !== 32'h11) begin bad++; $display("FAIL glitch_status: got %h want 11", d); end
      bus_read(2'd2, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL glitch_level: got %h want 0", d); end
   endtask

   task automatic test_ctrl_and_reset();
      logic [31:0] d;
      int lows;
      bus_write(2'd3, 32'h1);
      bus_read(2'd3, d);
      total++; if (d !== CTRL_EXP) begin bad++; $display("FAIL ctrl_bit0: got %h want %h", d, CTRL_EXP); end
      bus_write(2'd3, 32'h0);
      // Reset in the middle of a TX frame with bytes still queued.
      bus_write(2'd0, 32'h00);
      bus_write(2'd0, 32'h01);
      bus_write(2'd0, 32'h02);
      repeat (10) @(negedge clk);
      total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL midframe_busy: got %b want 0", uart_tx); end
      rstn = 1'b0;
      @(negedge clk);
      total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL midframe_reset_tx: got %b want 1", uart_tx); end
      rstn = 1'b1;
      bus_read(2'd2, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL midframe_level: got %h want 0", d); end
      bus_read(2'd0, d);
      total++; if (d !== 32'h11) begin bad++; $display("FAIL midframe_status: got %h want 11", d); end
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      total++; if (lows != 0) begin bad++; $display("FAIL midframe_quiet: low %0d cycles want 0", lows); end
   endtask

   initial begin
      test_reset();
      test_tx_single();
      test_back_to_back();
      test_rx_single();
      test_overrun();
      test_framing();
      test_ctrl_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
